// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit word-organised memory port between an
// instruction-fetch requester and a data requester.
//   clk, rst_n                         clock, asynchronous active-low reset
//   fetch_req/fetch_addr               fetch request (always a word read)
//   fetch_ready/fetch_data/fetch_err   fetch completion pulse, data, error
//   data_req/we/byte/addr/wdata        data request (read/write, byte/word)
//   data_ready/data_rdata/data_err     data completion pulse, data, error
//   mem_req/we/be/addr/wdata           memory request side
//   mem_ack/mem_rdata                  memory completion and read data
//   busy, dbg_state                    status: not idle, current state
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_ready,
    output logic [15:0] fetch_data,
    output logic        fetch_err,
    input  logic        data_req,
    input  logic        data_we,
    input  logic        data_byte,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    output logic        data_ready,
    output logic [15:0] data_rdata,
    output logic        data_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned WW = 8;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      starve_q, starve_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            owner_q, owner_d;   // 1 = data requester owns the access
    logic            addr0_q, addr0_d;
    logic            byte_q, byte_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [1:0]      mem_be_q, mem_be_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            fetch_ready_q, fetch_ready_d;
    logic [DW-1:0]   fetch_data_q, fetch_data_d;
    logic            fetch_err_q, fetch_err_d;
    logic            data_ready_q, data_ready_d;
    logic [DW-1:0]   data_rdata_q, data_rdata_d;
    logic            data_err_q, data_err_d;

    logic            grant_data, grant_fetch;
    logic [AW-1:0]   g_addr;
    logic            g_byte, g_we, misaligned;
    logic [DW-1:0]   lane_data;
    logic            rsp_valid, rsp_err;
    logic [DW-1:0]   rsp_data;

    // Data normally wins; fetch wins once it has been passed over three times.
    assign grant_data  = data_req && (!fetch_req || (starve_q != 2'd3));
    assign grant_fetch = fetch_req && !grant_data;
    assign g_addr      = grant_data ? data_addr : fetch_addr;
    assign g_byte      = grant_data && data_byte;
    assign g_we        = grant_data && data_we;
    assign misaligned  = !g_byte && g_addr[0];

    // Byte reads return the addressed lane zero-extended.
    assign lane_data = byte_q ? {8'h00, (addr0_q ? mem_rdata[15:8] : mem_rdata[7:0])}
                              : mem_rdata;

    // Next-state, request-side and response-side logic.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        owner_d     = owner_q;
        addr0_d     = addr0_q;
        byte_d      = byte_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_data    = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_data || grant_fetch) begin
                    wait_d  = '0;
                    owner_d = grant_data;
                    addr0_d = g_addr[0];
                    byte_d  = g_byte;
                    if (grant_fetch) begin
                        starve_d = '0;
                    end else if (fetch_req && (starve_q != 2'd3)) begin
                        starve_d = starve_q + 2'd1;
                    end
                    if (misaligned) begin
                        state_d   = S_RESP;
                        rsp_valid = 1'b1;
                        rsp_err   = 1'b1;
                    end else begin
                        state_d     = grant_data ? S_DATA : S_FETCH;
                        mem_we_d    = g_we;
                        mem_be_d    = g_byte ? (g_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                        mem_addr_d  = {g_addr[AW-1:1], 1'b0};
                        mem_wdata_d = !g_we ? '0
                                    : (g_byte ? {data_wdata[7:0], data_wdata[7:0]} : data_wdata);
                    end
                end
            end
            S_FETCH, S_DATA: begin
                if (mem_ack) begin
                    state_d   = S_RESP;
                    rsp_valid = 1'b1;
                    rsp_data  = lane_data;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_RESP;
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Memory request is live only while the next state waits on memory.
        mem_req_d = (state_d == S_FETCH) || (state_d == S_DATA);
        if (!mem_req_d) begin
            mem_we_d    = 1'b0;
            mem_be_d    = '0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
        end

        fetch_ready_d = rsp_valid && !owner_d;
        fetch_err_d   = rsp_valid && !owner_d && rsp_err;
        fetch_data_d  = (rsp_valid && !owner_d) ? rsp_data : '0;
        data_ready_d  = rsp_valid && owner_d;
        data_err_d    = rsp_valid && owner_d && rsp_err;
        data_rdata_d  = (rsp_valid && owner_d) ? rsp_data : '0;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            starve_q      <= '0;
            wait_q        <= '0;
            owner_q       <= 1'b0;
            addr0_q       <= 1'b0;
            byte_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            fetch_ready_q <= 1'b0;
            fetch_data_q  <= '0;
            fetch_err_q   <= 1'b0;
            data_ready_q  <= 1'b0;
            data_rdata_q  <= '0;
            data_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            wait_q        <= wait_d;
            owner_q       <= owner_d;
            addr0_q       <= addr0_d;
            byte_q        <= byte_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_be_q      <= mem_be_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            fetch_ready_q <= fetch_ready_d;
            fetch_data_q  <= fetch_data_d;
            fetch_err_q   <= fetch_err_d;
            data_ready_q  <= data_ready_d;
            data_rdata_q  <= data_rdata_d;
            data_err_q    <= data_err_d;
        end
    end

    assign fetch_ready = fetch_ready_q;
    assign fetch_data  = fetch_data_q;
    assign fetch_err   = fetch_err_q;
    assign data_ready  = data_ready_q;
    assign data_rdata  = data_rdata_q;
    assign data_err    = data_err_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_be      = mem_be_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles spent waiting for mem_ack before the access is aborted; legal range 1..255.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 fetch_req  in  1  instruction-fetch request; always a word read.
REQ-005 fetch_addr  in  16  byte address of the fetch.
REQ-006 fetch_ready / fetch_data / fetch_err  out  1/16/1  fetch completion pulse, read data, error flag.
REQ-007 data_req / data_we / data_byte  in  1/1/1  data-access request; 1=write / 0=read; 1=byte / 0=word.
REQ-008 data_addr / data_wdata  in  16/16  data byte address and write data.
REQ-009 data_ready / data_rdata / data_err  out  1/16/1  data completion pulse, read data, error flag.
REQ-010 mem_req / mem_we / mem_be  out  1/1/2  memory request, write enable, byte-lane enables {hi,lo}.
REQ-011 mem_addr / mem_wdata  out  16/16  word-aligned memory address and write data.
REQ-012 mem_ack / mem_rdata  in  1/16  memory completion and read data, both valid in the same cycle.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 dbg_state  out  2  encoding IDLE=0, FETCH=1, DATA=2, RESP=3.

Function
REQ-015 The block shall implement the states IDLE, FETCH, DATA and RESP and shall sample requests only in IDLE.
REQ-016 Arbitration in IDLE: if only one request is high, that request shall be granted; if both are high, data shall win unless starve_cnt==3, in which case fetch shall win.
REQ-017 starve_cnt (2-bit) shall increment, saturating at 3, on each data grant made while fetch_req is high, and shall clear on every fetch grant.
REQ-018 On grant, the block shall latch the address, write data, data_we, data_byte and owner; the inputs may change after the grant edge.
REQ-019 Misaligned access (word access with addr[0]=1, fetch or data): the block shall go IDLE->RESP with err=1 and read data 0, and shall not assert mem_req.
REQ-020 Aligned grant: the block shall go to FETCH or DATA with mem_req=1 from the next cycle until the edge at which mem_ack is sampled high; it shall then capture mem_rdata and go to RESP.
REQ-021 mem_addr shall be {addr[15:1],1'b0}.
REQ-022 mem_be shall be 2'b11 for a word access, 2'b01 for a byte access with addr[0]=0, and 2'b10 for a byte access with addr[0]=1.
REQ-023 mem_we shall be 1 only for data writes; fetch shall always read.
REQ-024 A byte write shall drive mem_wdata={wdata[7:0],wdata[7:0]}; a word write shall drive data_wdata unchanged.
REQ-025 A byte read shall return {8'h00, selected lane}; a word read shall return mem_rdata unchanged.
REQ-026 Timeout: wait_cnt shall clear on grant and increment each cycle in FETCH or DATA without ack; at wait_cnt==TIMEOUT-1 with no ack, the block shall go to RESP with err=1, read data 0, and mem_req low.
REQ-027 RESP shall last exactly one cycle, with the owner's ready=1 and data/err valid, and shall then go to IDLE.
REQ-028 Ready, data and err outputs shall be 0 outside RESP, and the non-owner's ready shall stay 0.
REQ-029 Minimum latency shall be 2 cycles from the request being sampled in IDLE to ready, when ack arrives in the first mem_req cycle; misaligned latency shall be 1 cycle.
REQ-030 Requesters shall deassert req in the cycle after ready; a req still high in IDLE shall be treated as a new request.
REQ-031 mem_ack received while mem_req=0 shall be ignored.
REQ-032 All outputs shall be registered or decoded from state registers only, with no combinational path from any input to any output.

Reset
REQ-033 Reset shall asynchronously force state to IDLE, starve_cnt and wait_cnt to 0, and every output to 0.
REQ-034 A reset asserted mid-access shall drop mem_req immediately, shall not produce a ready pulse, and shall leave no transaction to resume after reset.

Verification
REQ-035 Fetch at 0x0010, ack one cycle after mem_req -> mem_addr=0x0010, mem_be=11, fetch_ready 1 cycle, fetch_data=mem_rdata, fetch_err=0.
REQ-036 Byte read at 0x0021 with mem_rdata=0xBEEF -> mem_be=10, data_rdata=0x00BE; byte write 0x12A5 at 0x0020 -> mem_be=01, mem_wdata=0xA5A5, mem_we=1.
REQ-037 fetch_req and data_req held high continuously -> grant order D,D,D,F,D,D,D,F; no fetch waits for more than 3 data accesses.
REQ-038 Word data read at 0x0033 -> no mem_req, data_ready and data_err=1 one cycle after sampling, data_rdata=0.
REQ-039 TIMEOUT=4 with mem_ack held low -> mem_req high for exactly 4 cycles, then ready with err=1; a late ack while in IDLE has no effect.
REQ-040 rst_n pulsed low during DATA -> mem_req=0 asynchronously, no data_ready, dbg_state=0; a fresh fetch after reset completes normally.
